pe_alu_xbar_slice: RTL and testbench
====================================

Name: pe_alu_xbar_slice

Overview:
- Single-ALU processing-element slice for the CGRA fabric.
- A 4x4 fully-connected input crossbar feeds a registered two-operand ALU and two pass-through ports that drive an external memory unit.
- A 2x1 output switch selects the ALU result or the memory return as the slice output.
- All routing and opcode settings come from a 13-bit serial configuration chain that shifts on the data clock.

Parameters:
- size, 32, datapath width of every data port and the ALU.

Ports:
- clk  input  1  single clock; data and configuration registers both use its rising edge.
- reset  input  1  asynchronous, active-low; clears every register.
- config_en  input  1  1 = shift the configuration chain this cycle.
- config_in  input  1  serial configuration data in.
- config_out  output  1  serial configuration data out (cfg[12]).
- in0  input  size  data operand 0.
- in1  input  size  data operand 1.
- mem_in  input  size  result returned from the external memory unit.
- mem_op0  output  size  crossbar output 2, to the memory unit.
- mem_op1  output  size  crossbar output 3, to the memory unit.
- out0  output  size  slice output.

Behaviour:
- Config register cfg[12:0]:
  - reset low: cfg=0, asynchronously.
  - clk rise with config_en=1: cfg[0]<=config_in; cfg[i]<=cfg[i-1].
  - config_en=0: cfg holds.
  - Loading word W: present W[12] first and W[0] last, 13 enabled cycles.
  - config_out = cfg[12], registered.
- Field map:
  - opcode = cfg[3:0]
  - outsel = cfg[4]
  - xsel0 = cfg[6:5]
  - xsel1 = cfg[8:7]
  - xsel2 = cfg[10:9]
  - xsel3 = cfg[12:11]
- Crossbar (combinational): sources are 0=in0, 1=in1, 2=alu_q, 3=mem_in.
  - x0 = src[xsel0]; x1 = src[xsel1].
  - mem_op0 = src[xsel2]; mem_op1 = src[xsel3].
- ALU register alu_q (size bits):
  - reset low: 0.
  - clk rise with config_en=0: alu_q <= f(opcode, a=x0, b=x1).
  - config_en=1: alu_q holds.
  - Latency from operands to out0: one cycle.
- ALU opcodes (results truncated to size bits, wrap-around, no flags):
  - 0 add a+b; 1 sub a-b; 2 mul, low size bits of a*b.
  - 3 and; 4 or; 5 xor.
  - 6 shl a<<b[4:0]; 7 lshr a>>b[4:0]; 8 ashr, arithmetic a>>b[4:0].
  - 9 eq (1 if a==b else 0); 10 lt signed (1/0); 11 ltu unsigned (1/0).
  - 12 pass a; 13 pass b.
  - 14 min signed; 15 max signed.
  - Shift amount uses b[$clog2(size)-1:0].
- Output: out0 = outsel ? mem_in : alu_q (combinational).
- Reset state: opcode add, all crossbar selects = in0, outsel = ALU.
  - out0=0; mem_op0=mem_op1=in0; config_out=0.
- Simultaneous events:
  - Reset dominates the clock.
  - Configuration changes take effect combinationally on routing as soon as cfg updates; the ALU uses the new opcode on the first non-config edge.
- Feedback: src 2 (alu_q) is registered, so no combinational loop exists inside the slice.
  - mem_in -> mem_op* is combinational; the external memory must register.

Test Plan:
- Reset: drive reset=0 mid-operation with out0=0x1234 -> out0=0, config_out=0, mem_op0=in0 immediately, without waiting for a clock edge.
- Config load: shift W=13'b00_00_01_00_0_0000 (xsel1=in1, opcode add), then in0=5, in1=7 -> next edge out0=12. After a further 13 shifts of zeros, config_out has replayed W MSB-first.
- Opcode sweep: a=0xFFFFFFFF, b=1:
  - add -> 0; sub -> 0xFFFFFFFE; mul -> 0xFFFFFFFF.
  - lt -> 1; ltu -> 0.
  - ashr by 1 -> 0xFFFFFFFF; lshr -> 0x7FFFFFFF.
  - min -> 0xFFFFFFFF; max -> 1.
- Feedback accumulate: xsel0=alu_q, xsel1=in1, add, in1=3, alu_q starts at 0 after reset -> out0 = 3, 6, 9 on successive cycles.
- Memory path: xsel2=in1, xsel3=alu_q, outsel=1, mem_in=0xABCD -> mem_op0=in1, mem_op1=alu_q, out0=0xABCD the same cycle.
- Config freeze: hold config_en=1 during shifting -> alu_q unchanged regardless of in0/in1.

Source files
------------

// File: rtl/pe_alu_xbar_slice.sv
// CGRA PE slice: 4x4 input crossbar, registered 16-op ALU, 2x1 output switch, 13-bit serial config chain.
// Latency: one cycle from crossbar operands to out0 via alu_q; routing and the output switch are combinational.
// Backpressure: none; config_en=1 shifts the chain and freezes alu_q for that cycle.
module pe_alu_xbar_slice #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            config_en,
    input  logic            config_in,
    output logic            config_out,
    input  logic [size-1:0] in0,
    input  logic [size-1:0] in1,
    input  logic [size-1:0] mem_in,
    output logic [size-1:0] mem_op0,
    output logic [size-1:0] mem_op1,
    output logic [size-1:0] out0
);

    localparam int SHW = $clog2(size);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_LSHR = 4'd7;
    localparam logic [3:0] OP_ASHR = 4'd8;
    localparam logic [3:0] OP_EQ   = 4'd9;
    localparam logic [3:0] OP_LT   = 4'd10;
    localparam logic [3:0] OP_LTU  = 4'd11;
    localparam logic [3:0] OP_PASA = 4'd12;
    localparam logic [3:0] OP_PASB = 4'd13;
    localparam logic [3:0] OP_MIN  = 4'd14;
    localparam logic [3:0] OP_MAX  = 4'd15;

    logic [12:0]     cfg_q, cfg_d;
    logic [size-1:0] alu_q, alu_d, alu_res;
    logic [size-1:0] src [4];
    logic [size-1:0] x0, x1;
    logic [SHW-1:0]  shamt;

    logic [3:0] opcode;
    logic       outsel;
    logic [1:0] xsel0, xsel1, xsel2, xsel3;

    assign opcode = cfg_q[3:0];
    assign outsel = cfg_q[4];
    assign xsel0  = cfg_q[6:5];
    assign xsel1  = cfg_q[8:7];
    assign xsel2  = cfg_q[10:9];
    assign xsel3  = cfg_q[12:11];

    // alu_q feeds back through the registered source, so routing has no internal loop
    assign src[0] = in0;
    assign src[1] = in1;
    assign src[2] = alu_q;
    assign src[3] = mem_in;

    assign x0      = src[xsel0];
    assign x1      = src[xsel1];
    assign mem_op0 = src[xsel2];
    assign mem_op1 = src[xsel3];

    assign out0       = outsel ? mem_in : alu_q;
    assign config_out = cfg_q[12];
    assign shamt      = x1[SHW-1:0];

    // ALU function on the crossbar operands; comparisons return 0/1 in bit 0
    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = x0 + x1;
            OP_SUB:  alu_res = x0 - x1;
            OP_MUL:  alu_res = x0 * x1;
            OP_AND:  alu_res = x0 & x1;
            OP_OR:   alu_res = x0 | x1;
            OP_XOR:  alu_res = x0 ^ x1;
            OP_SHL:  alu_res = x0 << shamt;
            OP_LSHR: alu_res = x0 >> shamt;
            OP_ASHR: alu_res = $signed(x0) >>> shamt;
            OP_EQ:   alu_res[0] = (x0 == x1);
            OP_LT:   alu_res[0] = ($signed(x0) < $signed(x1));
            OP_LTU:  alu_res[0] = (x0 < x1);
            OP_PASA: alu_res = x0;
            OP_PASB: alu_res = x1;
            OP_MIN:  alu_res = ($signed(x0) < $signed(x1)) ? x0 : x1;
            OP_MAX:  alu_res = ($signed(x0) < $signed(x1)) ? x1 : x0;
            default: alu_res = '0;
        endcase
    end

    // Next state: shifting the chain and computing are mutually exclusive per cycle
    always_comb begin
        cfg_d = cfg_q;
        alu_d = alu_q;
        if (config_en) begin
            cfg_d = {cfg_q[11:0], config_in};
        end else begin
            alu_d = alu_res;
        end
    end

    // Config chain and ALU result register, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_q <= '0;
            alu_q <= '0;
        end else begin
            cfg_q <= cfg_d;
            alu_q <= alu_d;
        end
    end

endmodule

// File: tb/tb_pe_alu_xbar_slice.sv
// Self-checking bench for pe_alu_xbar_slice against a behavioural model.
// Latency: model tracks the one-cycle ALU register and combinational routing.
// Backpressure: none; config_en is driven randomly in the soak phase.
module tb_pe_alu_xbar_slice;

    logic        clk = 1'b0;
    logic        reset;
    logic        config_en;
    logic        config_in;
    logic        config_out;
    logic [31:0] in0, in1, mem_in;
    logic [31:0] mem_op0, mem_op1, out0;

    int n_chk  = 0;
    int n_pass = 0;

    // model state: the config bits as a history of shifted-in bits, plus the ALU value
    bit          cq[$];
    logic [31:0] m_alu = '0;

    pe_alu_xbar_slice #(.size(32)) dut (
        .clk(clk), .reset(reset),
        .config_en(config_en), .config_in(config_in), .config_out(config_out),
        .in0(in0), .in1(in1), .mem_in(mem_in),
        .mem_op0(mem_op0), .mem_op1(mem_op1), .out0(out0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // oldest surviving bit is the MSB of the current word
    function automatic logic [12:0] m_word();
        logic [12:0] w = '0;
        foreach (cq[i]) w = {w[11:0], cq[i]};
        return w;
    endfunction

    function automatic logic [12:0] mkw(input int op, input int osel, input int s0,
                                        input int s1, input int s2, input int s3);
        logic [12:0] w;
        w[3:0]   = op[3:0];
        w[4]     = osel[0];
        w[6:5]   = s0[1:0];
        w[8:7]   = s1[1:0];
        w[10:9]  = s2[1:0];
        w[12:11] = s3[1:0];
        return w;
    endfunction

    function automatic logic [31:0] m_src(input logic [1:0] s);
        case (s)
            2'd0:    return in0;
            2'd1:    return in1;
            2'd2:    return m_alu;
            default: return mem_in;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb, pw;
        int     sh;
        logic [63:0] r;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        sh = {27'b0, b[4:0]};
        pw = 64'd1 << sh;
        case (op)
            4'd0:  r = ua + ub;
            4'd1:  r = ua - ub;
            4'd2:  r = ua * ub;
            4'd3:  r = {32'b0, a & b};
            4'd4:  r = {32'b0, a | b};
            4'd5:  r = {32'b0, a ^ b};
            4'd6:  r = ua * pw;
            4'd7:  r = ua / pw;
            4'd8:  r = (sa >= 0) ? sa / pw : -((-sa + pw - 1) / pw);
            4'd9:  r = {63'b0, ua == ub};
            4'd10: r = {63'b0, sa < sb};
            4'd11: r = {63'b0, ua < ub};
            4'd12: r = ua;
            4'd13: r = ub;
            4'd14: r = (sa <= sb) ? ua : ub;
            default: r = (sa >= sb) ? ua : ub;
        endcase
        return r[31:0];
    endfunction

    // model of one rising edge, using the inputs held across it
    task automatic model_edge();
        logic [12:0] w;
        w = m_word();
        if (!reset) return;
        if (config_en) begin
            cq.push_back(config_in);
            if (cq.size() > 13) cq.delete(0);
        end else begin
            m_alu = ref_alu(w[3:0], m_src(w[6:5]), m_src(w[8:7]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [12:0] w;
        #1;
        w = m_word();
        chk({tag, ".out0"},    out0,    w[4] ? mem_in : m_alu);
        chk({tag, ".mem_op0"}, mem_op0, m_src(w[10:9]));
        chk({tag, ".mem_op1"}, mem_op1, m_src(w[12:11]));
        chk({tag, ".cfg_out"}, {31'b0, config_out}, {31'b0, w[12]});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cq.delete();
        m_alu = '0;
        #1;
        check_all("rst");
        #1;
        reset = 1'b1;
    endtask

    task automatic shift_word(input logic [12:0] w);
        for (int i = 12; i >= 0; i--) begin
            config_en = 1'b1;
            config_in = w[i];
            in0 = $urandom;
            in1 = $urandom;
            step();
        end
        config_en = 1'b0;
    endtask

    logic [12:0] wl;
    logic [3:0]  sweep_op  [9] = '{4'd0, 4'd1, 4'd2, 4'd10, 4'd11, 4'd8, 4'd7, 4'd14, 4'd15};
    logic [31:0] sweep_exp [9] = '{32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1, 32'h0,
                                   32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h1};

    initial begin
        reset = 1'b0; config_en = 1'b0; config_in = 1'b0;
        in0 = $urandom; in1 = $urandom; mem_in = $urandom;
        #1;
        check_all("por");
        chk("por.out0_zero", out0, 32'h0);
        chk("por.mem_op0_in0", mem_op0, in0);
        #1 reset = 1'b1;

        // load W, then 5+7 through the adder
        wl = mkw(0, 0, 0, 1, 0, 0);
        shift_word(wl);
        in0 = 32'd5; in1 = 32'd7;
        check_all("load_pre");
        step();
        check_all("load");
        chk("load.sum", out0, 32'd12);

        // shifting zeros replays W on config_out MSB-first
        for (int k = 0; k < 13; k++) begin
            chk($sformatf("replay%0d", k), {31'b0, config_out}, {31'b0, wl[12-k]});
            config_en = 1'b1; config_in = 1'b0;
            step();
        end
        config_en = 1'b0;

        // opcode sweep with a=all ones, b=1
        for (int i = 0; i < 9; i++) begin
            shift_word(mkw(int'(sweep_op[i]), 0, 0, 1, 0, 0));
            in0 = 32'hFFFFFFFF; in1 = 32'd1;
            step();
            check_all($sformatf("sweep_op%0d", sweep_op[i]));
            chk($sformatf("sweep_exp_op%0d", sweep_op[i]), out0, sweep_exp[i]);
        end

        // feedback accumulate from a cleared alu_q
        do_reset();
        shift_word(mkw(0, 0, 2, 1, 0, 0));
        in1 = 32'd3;
        for (int k = 0; k < 3; k++) begin
            step();
            check_all("acc");
            chk($sformatf("acc%0d", k), out0, 32'd3 * (k + 1));
        end

        // memory path routing and output switch
        shift_word(mkw(0, 1, 0, 0, 1, 2));
        in1 = $urandom; mem_in = 32'hABCD;
        check_all("mem");
        chk("mem.op0_in1", mem_op0, in1);
        chk("mem.op1_alu", mem_op1, 32'd9);
        chk("mem.out0", out0, 32'hABCD);

        // alu_q frozen while shifting despite changing operands
        shift_word(mkw(12, 0, 0, 0, 0, 0));
        check_all("freeze");
        chk("freeze.out0", out0, 32'd9);

        // asynchronous reset mid-operation
        in0 = 32'h1234;
        step();
        check_all("pre_rst");
        chk("pre_rst.out0", out0, 32'h1234);
        #2;
        reset = 1'b0;
        cq.delete();
        m_alu = '0;
        #1;
        chk("arst.out0", out0, 32'h0);
        chk("arst.cfg_out", {31'b0, config_out}, 32'h0);
        chk("arst.mem_op0", mem_op0, in0);
        #1 reset = 1'b1;

        // random soak with interleaved configuration shifting
        for (int k = 0; k < 400; k++) begin
            config_en = ($urandom_range(0, 3) == 0);
            config_in = $urandom_range(0, 1) == 1;
            in0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            in1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            mem_in = $urandom;
            check_all("soak");
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
